fp_bcd_converter: RTL and testbench

FP_BCD_CONVERTER -- requirements
Module: fp_bcd_converter

---
 rtl/fp_bcd_pkg.sv | 43 ++++
 rtl/fp_bcd_converter_dabble.sv | 33 +++
 rtl/fp_bcd_converter.sv | 107 ++++++++++
 tb/tb_fp_bcd_converter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_bcd_pkg.sv
// ---------------------------------------------------------------------------
// fp_bcd_pkg
// Shared widths and constants for the fixed-point <-> BCD converter, plus
// the BCD digit helpers used by the top level.
//   BCD word : 12 packed digits, [47:24] integer, [23:0] fraction, MS first
//   BIN word : unsigned Q20.20, [39:20] integer, [19:0] fraction
// ---------------------------------------------------------------------------
package fp_bcd_pkg;

    localparam int INT_DIGITS  = 6;
    localparam int FRAC_DIGITS = 6;
    localparam int FRAC_BITS   = 20;
    localparam int BIN_W       = 40;
    localparam int BCD_W       = 48;
    localparam int HALF_W      = 4 * FRAC_DIGITS;   // one 6-digit BCD half
    localparam int PROD_W      = 40;                // scaled fraction products

    localparam logic [PROD_W-1:0]    DEC_SCALE = 40'd1000000;  // 10^6
    localparam logic [FRAC_BITS-1:0] INT_MAX   = 20'd999999;
    localparam logic [BCD_W-1:0]     BCD_SAT   = 48'h999999999999;

    // Horner evaluation of a 6-digit BCD half: acc = acc*10 + digit.
    // Result fits 20 bits for legal digits; illegal digits are masked by
    // the caller through bcd_bad_digit().
    function automatic logic [FRAC_BITS-1:0] bcd6_to_bin(input logic [HALF_W-1:0] digits);
        logic [FRAC_BITS-1:0] acc;
        acc = '0;
        for (int i = INT_DIGITS - 1; i >= 0; i--) begin
            acc = FRAC_BITS'(acc * FRAC_BITS'(10)) + FRAC_BITS'(digits[4*i +: 4]);
        end
        return acc;
    endfunction

    function automatic logic bcd_bad_digit(input logic [BCD_W-1:0] digits);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < INT_DIGITS + FRAC_DIGITS; i++) begin
            if (digits[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/fp_bcd_converter_dabble.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_digits
// Combinational 20-bit binary to 6-digit BCD (double-dabble / shift-add-3).
//   i_bin : binary value, meaningful range 0..999999
//   o_bcd : 6 packed BCD digits, MS digit at [23:20]
// Inputs above 999999 lose their seventh digit; the caller saturates.
// ---------------------------------------------------------------------------
module bin_to_bcd_digits
    import fp_bcd_pkg::*;
(
    input  logic [FRAC_BITS-1:0] i_bin,
    output logic [HALF_W-1:0]    o_bcd
);

    logic [HALF_W-1:0] w_bcd;

    always_comb begin
        // NOTE: every variable assigned in always_comb gets a value up front,
        // so no path can leave it unassigned and infer a latch.
        w_bcd = '0;
        for (int i = FRAC_BITS - 1; i >= 0; i--) begin
            // Pre-correct any digit >= 5 so the following shift carries into
            // the next decade instead of producing a code of 10..15.
            for (int d = 0; d < INT_DIGITS; d++) begin
                if (w_bcd[4*d +: 4] >= 4'd5) w_bcd[4*d +: 4] = w_bcd[4*d +: 4] + 4'd3;
            end
            w_bcd = {w_bcd[HALF_W-2:0], i_bin[i]};
        end
    end

    assign o_bcd = w_bcd;

endmodule

// File: rtl/fp_bcd_converter.sv
// ---------------------------------------------------------------------------
// fp_bcd_converter
// Converts 12-digit fixed-point BCD to unsigned Q20.20 and, independently,
// Q20.20 to 12-digit BCD. Both directions are combinational; only the
// outputs are registered, giving a fixed one-cycle latency.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   in_valid  : bcd_in / bin_in qualify this cycle
//   bcd_in    : 6.6 packed BCD digits
//   bin_in    : Q20.20 unsigned
//   out_valid : registered results valid
//   bin_out   : Q20.20 of bcd_in (0 when bcd_err)
//   bcd_out   : BCD of bin_in (all nines when bcd_ovf)
//   bcd_err   : bcd_in held a digit above 9
//   bcd_ovf   : bin_in integer part above 999999
// ---------------------------------------------------------------------------
module fp_bcd_converter
    import fp_bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [BCD_W-1:0] bcd_in,
    input  logic [BIN_W-1:0] bin_in,
    output logic             out_valid,
    output logic [BIN_W-1:0] bin_out,
    output logic [BCD_W-1:0] bcd_out,
    output logic             bcd_err,
    output logic             bcd_ovf
);

    // ---------------- BCD -> binary ----------------
    logic [FRAC_BITS-1:0] w_int_bin;
    logic [FRAC_BITS-1:0] w_frac_dec;
    logic [PROD_W-1:0]    w_frac_scaled;
    logic [FRAC_BITS-1:0] w_frac_bin;
    logic                 w_bcd_err;
    logic [BIN_W-1:0]     w_bin_next;

    assign w_int_bin     = bcd6_to_bin(bcd_in[BCD_W-1:HALF_W]);
    assign w_frac_dec    = bcd6_to_bin(bcd_in[HALF_W-1:0]);
    // F * 2^20 / 10^6, truncating; the 40-bit product cannot overflow.
    assign w_frac_scaled = {w_frac_dec, {FRAC_BITS{1'b0}}};
    assign w_frac_bin    = FRAC_BITS'(w_frac_scaled / DEC_SCALE);
    assign w_bcd_err     = bcd_bad_digit(bcd_in);
    assign w_bin_next    = w_bcd_err ? '0 : {w_int_bin, w_frac_bin};

    // ---------------- binary -> BCD ----------------
    logic [PROD_W-1:0]    w_frac_prod;
    logic [FRAC_BITS-1:0] w_frac_dec_out;
    logic [HALF_W-1:0]    w_int_bcd;
    logic [HALF_W-1:0]    w_frac_bcd;
    logic                 w_bcd_ovf;
    logic [BCD_W-1:0]     w_bcd_next;

    // frac * 10^6 / 2^20, truncating; result is always <= 999999.
    assign w_frac_prod    = PROD_W'(bin_in[FRAC_BITS-1:0]) * DEC_SCALE;
    assign w_frac_dec_out = FRAC_BITS'(w_frac_prod >> FRAC_BITS);
    assign w_bcd_ovf      = bin_in[BIN_W-1:FRAC_BITS] > INT_MAX;

    bin_to_bcd_digits u_int_digits (
        .i_bin (bin_in[BIN_W-1:FRAC_BITS]),
        .o_bcd (w_int_bcd)
    );

    bin_to_bcd_digits u_frac_digits (
        .i_bin (w_frac_dec_out),
        .o_bcd (w_frac_bcd)
    );

    assign w_bcd_next = w_bcd_ovf ? BCD_SAT : {w_int_bcd, w_frac_bcd};

    // ---------------- output registers ----------------
    logic             r_out_valid;
    logic [BIN_W-1:0] r_bin_out;
    logic [BCD_W-1:0] r_bcd_out;
    logic             r_bcd_err;
    logic             r_bcd_ovf;

    // NOTE: clocked state uses non-blocking (<=) so all registers update
    // together from pre-edge values, matching the hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_bin_out   <= '0;
            r_bcd_out   <= '0;
            r_bcd_err   <= 1'b0;
            r_bcd_ovf   <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            // Data and flags only move on valid cycles, otherwise they hold.
            if (in_valid) begin
                r_bin_out <= w_bin_next;
                r_bcd_out <= w_bcd_next;
                r_bcd_err <= w_bcd_err;
                r_bcd_ovf <= w_bcd_ovf;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign bin_out   = r_bin_out;
    assign bcd_out   = r_bcd_out;
    assign bcd_err   = r_bcd_err;
    assign bcd_ovf   = r_bcd_ovf;

endmodule

// File: tb/tb_fp_bcd_converter.sv
// ---------------------------------------------------------------------------
// tb_fp_bcd_converter
// Directed bench for fp_bcd_converter with hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_fp_bcd_converter;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [47:0] bcd_in;
    logic [39:0] bin_in;
    logic        out_valid;
    logic [39:0] bin_out;
    logic [47:0] bcd_out;
    logic        bcd_err;
    logic        bcd_ovf;

    int checks;
    int errors;

    fp_bcd_converter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .bcd_in    (bcd_in),
        .bin_in    (bin_in),
        .out_valid (out_valid),
        .bin_out   (bin_out),
        .bcd_out   (bcd_out),
        .bcd_err   (bcd_err),
        .bcd_ovf   (bcd_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Apply inputs, then step one edge and settle 1 time unit past it.
    task automatic drive(input logic v, input logic [47:0] bcd, input logic [39:0] bin);
        in_valid = v;
        bcd_in   = bcd;
        bin_in   = bin;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b0, 48'h0, 40'h0);
        drive(1'b0, 48'h0, 40'h0);
        checks++;
        if ({out_valid, bin_out, bcd_out, bcd_err, bcd_ovf} !== 91'h0) begin
            errors++;
            $display("FAIL reset_state: got v=%b bin=%h bcd=%h err=%b ovf=%b, want all 0",
                     out_valid, bin_out, bcd_out, bcd_err, bcd_ovf);
        end
        rst = 1'b0;
    endtask

    task automatic test_bcd_to_bin;
        drive(1'b1, 48'h000001500000, 40'h0);
        checks++;
        if (out_valid !== 1'b1 || bin_out !== 40'h0000180000 || bcd_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_1p5: got v=%b bin=%h err=%b, want 1 0000180000 0", out_valid, bin_out, bcd_err);
        end
        drive(1'b1, 48'h123456789012, 40'h0);
        checks++;
        if (bin_out !== 40'h1E240C9FCB || bcd_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_mixed: got bin=%h err=%b, want 1E240C9FCB 0", bin_out, bcd_err);
        end
        drive(1'b1, 48'h999999999999, 40'h0);
        checks++;
        if (bin_out !== 40'hF423FFFFFE || bcd_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_max: got bin=%h err=%b, want F423FFFFFE 0", bin_out, bcd_err);
        end
    endtask

    task automatic test_bin_to_bcd;
        drive(1'b1, 48'h0, 40'h0000040000);
        checks++;
        if (bcd_out !== 48'h000000250000 || bcd_ovf !== 1'b0) begin
            errors++;
            $display("FAIL bin2bcd_quarter: got bcd=%h ovf=%b, want 000000250000 0", bcd_out, bcd_ovf);
        end
        drive(1'b1, 48'h0, 40'h0007B80000);
        checks++;
        if (bcd_out !== 48'h000123500000 || bcd_ovf !== 1'b0) begin
            errors++;
            $display("FAIL bin2bcd_123p5: got bcd=%h ovf=%b, want 000123500000 0", bcd_out, bcd_ovf);
        end
    endtask

    task automatic test_round_trip;
        drive(1'b1, 48'h000000100000, 40'h0);
        checks++;
        if (bin_out !== 40'h0000019999) begin
            errors++;
            $display("FAIL trunc_b2b: got bin=%h, want 0000019999", bin_out);
        end
        drive(1'b1, 48'h0, 40'h0000019999);
        checks++;
        if (bcd_out !== 48'h000000099999) begin
            errors++;
            $display("FAIL trunc_bin2bcd: got bcd=%h, want 000000099999", bcd_out);
        end
    endtask

    task automatic test_overflow;
        drive(1'b1, 48'h0, 40'hF424000000);
        checks++;
        if (bcd_out !== 48'h999999999999 || bcd_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_1e6: got bcd=%h ovf=%b, want 999999999999 1", bcd_out, bcd_ovf);
        end
        drive(1'b1, 48'h0, 40'hF423F00000);
        checks++;
        if (bcd_out !== 48'h999999000000 || bcd_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_edge: got bcd=%h ovf=%b, want 999999000000 0", bcd_out, bcd_ovf);
        end
        drive(1'b1, 48'h0, 40'hF423FFFFFF);
        checks++;
        if (bcd_out !== 48'h999999999999 || bcd_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_maxfrac: got bcd=%h ovf=%b, want 999999999999 0", bcd_out, bcd_ovf);
        end
    endtask

    task automatic test_bad_digit;
        // Bad BCD alongside a good binary input: the directions are independent.
        drive(1'b1, 48'h00000A000000, 40'h0000040000);
        checks++;
        if (bcd_err !== 1'b1 || bin_out !== 40'h0 || bcd_out !== 48'h000000250000 || bcd_ovf !== 1'b0) begin
            errors++;
            $display("FAIL bad_int_digit: got err=%b bin=%h bcd=%h ovf=%b, want 1 0 000000250000 0",
                     bcd_err, bin_out, bcd_out, bcd_ovf);
        end
        drive(1'b1, 48'h0000000000F0, 40'h0);
        checks++;
        if (bcd_err !== 1'b1 || bin_out !== 40'h0) begin
            errors++;
            $display("FAIL bad_frac_digit: got err=%b bin=%h, want 1 0", bcd_err, bin_out);
        end
    endtask

    task automatic test_hold;
        drive(1'b1, 48'h000001500000, 40'hF424000000);
        // Idle cycle with different inputs: outputs must not move.
        drive(1'b0, 48'h00000A000000, 40'h0000040000);
        checks++;
        if (out_valid !== 1'b0 || bin_out !== 40'h0000180000 || bcd_out !== 48'h999999999999
            || bcd_err !== 1'b0 || bcd_ovf !== 1'b1) begin
            errors++;
            $display("FAIL hold: got v=%b bin=%h bcd=%h err=%b ovf=%b, want 0 0000180000 999999999999 0 1",
                     out_valid, bin_out, bcd_out, bcd_err, bcd_ovf);
        end
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 48'h000001500000, 40'h0000040000);
        checks++;
        if (out_valid !== 1'b1 || bin_out !== 40'h0000180000 || bcd_out !== 48'h000000250000) begin
            errors++;
            $display("FAIL b2b_beat0: got v=%b bin=%h bcd=%h, want 1 0000180000 000000250000",
                     out_valid, bin_out, bcd_out);
        end
        drive(1'b1, 48'h000000100000, 40'h0000019999);
        checks++;
        if (out_valid !== 1'b1 || bin_out !== 40'h0000019999 || bcd_out !== 48'h000000099999) begin
            errors++;
            $display("FAIL b2b_beat1: got v=%b bin=%h bcd=%h, want 1 0000019999 000000099999",
                     out_valid, bin_out, bcd_out);
        end
        drive(1'b1, 48'h00000A000000, 40'hF424000000);
        checks++;
        if (out_valid !== 1'b1 || bcd_err !== 1'b1 || bcd_ovf !== 1'b1) begin
            errors++;
            $display("FAIL b2b_beat2: got v=%b err=%b ovf=%b, want 1 1 1", out_valid, bcd_err, bcd_ovf);
        end
    endtask

    task automatic test_reset_priority;
        drive(1'b1, 48'h000001500000, 40'hF424000000);
        // Reset arrives with in_valid high: the in-flight result is discarded.
        rst = 1'b1;
        drive(1'b1, 48'h123456789012, 40'hF424000000);
        checks++;
        if ({out_valid, bin_out, bcd_out, bcd_err, bcd_ovf} !== 91'h0) begin
            errors++;
            $display("FAIL reset_priority: got v=%b bin=%h bcd=%h err=%b ovf=%b, want all 0",
                     out_valid, bin_out, bcd_out, bcd_err, bcd_ovf);
        end
        rst = 1'b0;
        drive(1'b0, 48'h0, 40'h0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got v=%b, want 0", out_valid);
        end
        drive(1'b1, 48'h000001500000, 40'h0000040000);
        checks++;
        if (out_valid !== 1'b1 || bin_out !== 40'h0000180000 || bcd_out !== 48'h000000250000) begin
            errors++;
            $display("FAIL pulse_high: got v=%b bin=%h bcd=%h, want 1 0000180000 000000250000",
                     out_valid, bin_out, bcd_out);
        end
        drive(1'b0, 48'h0, 40'h0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL pulse_low: got v=%b, want 0", out_valid);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        bcd_in   = '0;
        bin_in   = '0;
        test_reset();
        test_bcd_to_bin();
        test_bin_to_bcd();
        test_round_trip();
        test_overflow();
        test_bad_digit();
        test_hold();
        test_back_to_back();
        test_reset_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
